// File: rtl/tug_score_counter_if.sv
// Board-side bundle for the tug-of-war score counter: raw buttons and restart in, score and LEDs out.
// No valid/ready handshake: pbl/pbr are asynchronous levels, restart is a clk-domain level, and every output is valid on every cycle.
interface tug_score_counter_if #(
    parameter int WIDTH = 7
);
    logic             pbl;
    logic             pbr;
    logic             restart;
    logic [WIDTH-1:0] count;
    logic             win_left;
    logic             win_right;
    logic             at_min;
    logic             at_max;
    logic [3:0]       status;
    logic [1:0]       state_dbg;

    modport master (
        output pbl, pbr, restart,
        input  count, win_left, win_right, at_min, at_max, status, state_dbg
    );

    modport slave (
        input  pbl, pbr, restart,
        output count, win_left, win_right, at_min, at_max, status, state_dbg
    );
endinterface

// File: rtl/tug_score_counter.sv
// Up/down score counter for the tug-of-war game: synchronised, edge-detected buttons,
// wrap-around counting in MODE 0, saturating game with winner detection in MODE 1.
module tug_score_counter #(
    parameter int WIDTH       = 7,
    parameter int RESET_VAL   = 64,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 1
) (
    input  logic                clk,
    input  logic                rst,
    tug_score_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MAX_CNT   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_CNT  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_CNT   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        LEFT_WIN  = 2'd1,
        RIGHT_WIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               win_left_q, win_right_q;
    logic [SYNC_STAGES-1:0] sync_l_q, sync_r_q;
    logic               prev_l_q, prev_r_q;
    logic               sync_l, sync_r;
    logic               dn_pulse, up_pulse;

    assign sync_l   = sync_l_q[SYNC_STAGES-1];
    assign sync_r   = sync_r_q[SYNC_STAGES-1];
    assign dn_pulse = sync_l & ~prev_l_q;
    assign up_pulse = sync_r & ~prev_r_q;

    // Synchronisers and edge history run in every state so a held button never re-triggers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_l_q <= '0;
            sync_r_q <= '0;
            prev_l_q <= 1'b0;
            prev_r_q <= 1'b0;
        end else begin
            sync_l_q <= {sync_l_q[SYNC_STAGES-2:0], bus.pbl};
            sync_r_q <= {sync_r_q[SYNC_STAGES-2:0], bus.pbr};
            prev_l_q <= sync_l;
            prev_r_q <= sync_r;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (bus.restart) begin
            state_d = PLAY;
            count_d = RESET_CNT;
        end else begin
            case (state_q)
                PLAY: begin
                    if (dn_pulse && !up_pulse) begin
                        count_d = count_q - ONE_CNT;
                    end else if (up_pulse && !dn_pulse) begin
                        count_d = count_q + ONE_CNT;
                    end
                    // RESET_VAL sits strictly inside the range, so reaching an end implies a step.
                    if (MODE != 0) begin
                        if (count_d == ZERO_CNT) begin
                            state_d = LEFT_WIN;
                        end else if (count_d == MAX_CNT) begin
                            state_d = RIGHT_WIN;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PLAY;
            count_q     <= RESET_CNT;
            win_left_q  <= 1'b0;
            win_right_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            win_left_q  <= (state_d == LEFT_WIN);
            win_right_q <= (state_d == RIGHT_WIN);
        end
    end

    assign bus.count     = count_q;
    assign bus.win_left  = win_left_q;
    assign bus.win_right = win_right_q;
    assign bus.at_min    = (count_q == ZERO_CNT);
    assign bus.at_max    = (count_q == MAX_CNT);
    assign bus.status    = {~win_right_q, ~win_left_q, ~bus.at_max, ~bus.at_min};
    assign bus.state_dbg = state_q;
endmodule

// File: doc/tug_score_counter.md
Name: tug_score_counter

Overview:
Parametrised up/down score counter for the tug-of-war game datapath. It synchronises the two raw push-buttons and edge-detects them, so each press moves the score by exactly one step. It supports a wrap-around counter mode and a game mode that saturates at the ends and declares a winner. The block drives the LED bar and the status LEDs and sits between the board button pins and the display logic.

Parameters:
WIDTH, 7, score counter width in bits; MAX = 2^WIDTH-1
RESET_VAL, 64, score loaded on reset and on restart; game mode requires 0 < RESET_VAL < MAX
SYNC_STAGES, 2, flip-flop stages in each button synchroniser (>=2)
MODE, 1, 0 = free-running wrap counter with no win logic; 1 = game mode with saturation and win detection

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
pbl  input  1  raw left push-button (asynchronous); each press decrements the score
pbr  input  1  raw right push-button (asynchronous); each press increments the score
restart  input  1  synchronous, clk-domain, active-high; leaves a win state
count  output  WIDTH  current score, registered
win_left  output  1  registered; high while in state LEFT_WIN
win_right  output  1  registered; high while in state RIGHT_WIN
at_min  output  1  combinational from count; high when count == 0
at_max  output  1  combinational from count; high when count == MAX
status  output  4  active-low LEDs {~win_right, ~win_left, ~at_max, ~at_min}

Behaviour:
- Reset (asynchronous, any time including mid-press or in a win state):
  - count = RESET_VAL; state = PLAY; win_left = win_right = 0.
  - All synchroniser and edge-history flops = 0.
  - status = 4'b1111, unless RESET_VAL is 0 or MAX (legal in MODE 0 only).
- Synchroniser: each button passes through a SYNC_STAGES flop chain. dn_pulse = sync_l & ~prev_l; up_pulse = sync_r & ~prev_r. prev regs track the sync outputs every cycle.
- Latency: a button that first samples high at edge k changes count at edge k+SYNC_STAGES. A held button gives exactly one step. Release and re-press give a new step.
- Step decode:
  - dn_pulse & ~up_pulse -> -1.
  - up_pulse & ~dn_pulse -> +1.
  - Both or neither -> no change. Simultaneous presses cancel.
- MODE 0:
  - Arithmetic is modulo 2^WIDTH: 0 - 1 -> MAX, MAX + 1 -> 0.
  - State stays PLAY; win outputs stay 0; restart reloads RESET_VAL.
- MODE 1 FSM, states PLAY, LEFT_WIN, RIGHT_WIN:
  - PLAY: apply the step.
    - If next count == 0: go to LEFT_WIN on the same edge count becomes 0, and win_left rises on that edge.
    - If next count == MAX: go to RIGHT_WIN on the same edge count becomes MAX, and win_right rises on that edge.
    - No wrap ever occurs.
  - LEFT_WIN / RIGHT_WIN: count frozen; button pulses ignored, but the synchronisers keep running.
    - restart -> PLAY with count = RESET_VAL and win flags cleared, on the next edge.
  - restart high in PLAY: count reloads RESET_VAL. Restart has priority over any same-cycle step.
- Buttons held across a restart do not generate a step, because the edge history is still high.
- at_min and at_max are valid in every state and mode.

Test Plan:
1. Reset, then pulse pbr high for 5 cycles with defaults -> count 64 -> 65 exactly SYNC_STAGES (2) edges after first sampling, then holds at 65; status = 4'b1111.
2. Hold pbl for 50 cycles, release, then press twice more -> count decrements by exactly 3 total (64 -> 61).
3. Assert pbl and pbr on the same cycle, stable for 10 cycles -> count stays 64; no pulse effect.
4. MODE 1: 63 separate pbr presses from 64 -> count 127, win_right = 1, status = 4'b0101. Further presses leave count at 127. restart for 1 cycle -> count 64, win_right = 0 on the next edge.
5. MODE 0 with RESET_VAL 0, one pbl press -> count wraps to 127. One pbr press -> count 0. Win outputs stay 0 throughout.
6. MODE 1, reach LEFT_WIN (count 0), then assert rst asynchronously between clock edges -> count 64, win_left 0, all immediately. After release, a first press counts normally.
